ahb_apb3_bridge_mc: RTL and testbench
=====================================

# ahb_apb3_bridge_mc

Parametrised multi-slave AHB-Lite to APB3 bridge, the successor to the single-PSEL bridge instance used between the processor AHB fabric and the peripheral APB bus. It converts one AHB slave port into APB3 transfers over a shared PADDR/PWDATA bus with NUM_SLAVES decoded PSEL lines and per-slave PRDATA/PREADY/PSLVERR return paths. It also adds two behaviours the previous bridge lacks: an error response for undecoded addresses, and a programmable PREADY timeout.

## Interface
- ADDR_WIDTH, 32, HADDR/PADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA/PWDATA/PRDATA lane width
- NUM_SLAVES, 4, number of APB slots (1..16)
- SLOT_BITS, 12, slot index taken from HADDR[SLOT_BITS +: IDX_W], IDX_W = max(1, clog2(NUM_SLAVES))
- TIMEOUT, 255, maximum ACCESS cycles before forced error; 0 disables the timeout
- HCLK  in  1  sole clock, rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL, HREADY, HWRITE  in  1  AHB-Lite slave controls
- HTRANS  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ
- HADDR  in  ADDR_WIDTH  AHB address
- HWDATA  in  DATA_WIDTH  AHB write data, valid in the data phase
- HRDATA  out  DATA_WIDTH  registered read data
- HREADYOUT  out  1  AHB ready
- HRESP  out  2  00 OKAY, 01 ERROR
- PADDR  out  ADDR_WIDTH  registered HADDR
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE, PWRITE  out  1  APB3 controls
- PWDATA  out  DATA_WIDTH  registered write data
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- PREADY, PSLVERR  in  NUM_SLAVES  per-slave ready and error

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1] on a rising edge while the state is IDLE or ERR2. On accept, capture HADDR, HWRITE and the slot index.
- States and transitions:
  - IDLE: HREADYOUT=1, HRESP=00. Accept with slot < NUM_SLAVES goes to LATCH; accept with slot >= NUM_SLAVES goes to ERR1 with no APB activity.
  - LATCH: HREADYOUT=0. Register HWDATA into PWDATA (writes only; reads leave PWDATA unchanged). Go to SETUP.
  - SETUP: PSEL[slot]=1, PENABLE=0. Go to ACCESS.
  - ACCESS: PSEL[slot]=1, PENABLE=1. Timeout counter increments each cycle.
    - PREADY[slot]=1 and PSLVERR[slot]=0: register PRDATA[slot] into HRDATA on reads, then go to IDLE.
    - PREADY[slot]=1 and PSLVERR[slot]=1: go to ERR1.
    - PREADY[slot]=0 with counter == TIMEOUT-1 and TIMEOUT != 0: go to ERR1 and drop PSEL/PENABLE.
  - ERR1: HREADYOUT=0, HRESP=01. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Go to IDLE, or to LATCH/ERR1 on a new accept.
- PREADY/PSLVERR/PRDATA of unselected slaves are ignored. PADDR, PWRITE and PWDATA hold from SETUP through ACCESS and may hold stale values in IDLE.
- Back-to-back transfers: an accept in IDLE enters LATCH directly, with no extra idle cycle.
- HTRANS IDLE/BUSY or HSEL=0 in IDLE: no state change, OKAY response.

## Timing
- Reset values (asynchronous, immediate on HRESET high, including mid-transfer):
  - state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout counter 0
- An APB slave seeing its transfer aborted by reset sees PSEL fall without completion.
- Zero-wait-state slave latency: accept at edge 0; LATCH cycle 1, SETUP cycle 2, ACCESS cycle 3, HREADYOUT=1 with valid HRDATA in cycle 4. AHB data phase is 4 cycles; each PREADY wait adds 1.
- Timeout: ERR1 follows exactly TIMEOUT ACCESS cycles with PREADY low. PREADY=1 on the final counted cycle wins over the timeout.
- Decode error: accept at edge 0, ERR1 in cycle 1, ERR2 in cycle 2. No PSEL asserted.
- HRESP is 01 in both ERR1 and ERR2, so the error response is the standard two cycles.

## Test plan
- Write 0xDEADBEEF to slot 2 (HADDR=0x2010), zero-wait slave:
  - PSEL=0100, PADDR=0x2010, PWRITE=1, PWDATA=0xDEADBEEF; SETUP in cycle 2, ACCESS in cycle 3.
  - HREADYOUT low in cycles 1-3, high in cycle 4, HRESP=00.
- Read from slot 1 with PREADY low for 3 cycles, PRDATA=0x12345678:
  - HRDATA=0x12345678 with HREADYOUT=1 in cycle 7.
  - PENABLE high for exactly 4 cycles.
- Access to HADDR=0x5000 with NUM_SLAVES=4:
  - No PSEL asserted.
  - HRESP=01 in cycles 1-2; HREADYOUT=0 in cycle 1, 1 in cycle 2.
- PSLVERR=1 together with PREADY=1 on slot 0: ERR1 then ERR2 response; PSEL drops the cycle after ACCESS.
- TIMEOUT=8 with PREADY held low:
  - PSEL/PENABLE drop after 8 ACCESS cycles, followed by the two-cycle error.
  - A new accept in ERR2 starts a normal transfer.
- HRESET pulsed during ACCESS: all outputs take reset values in the same cycle, and the next accept completes normally.

Source files
------------

// File: rtl/ahb_apb3_bridge_mc.sv
// ahb_apb3_bridge_mc: AHB-Lite slave to multi-slot APB3 master bridge with decode-error and PREADY timeout.
module ahb_apb3_bridge_mc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLOT_BITS  = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                             hclk_i,
  input  logic                             hreset_i,
  input  logic                             hsel_i,
  input  logic                             hready_i,
  input  logic                             hwrite_i,
  input  logic [1:0]                       htrans_i,
  input  logic [ADDR_WIDTH-1:0]            haddr_i,
  input  logic [DATA_WIDTH-1:0]            hwdata_i,
  output logic [DATA_WIDTH-1:0]            hrdata_o,
  output logic                             hreadyout_o,
  output logic [1:0]                       hresp_o,
  output logic [ADDR_WIDTH-1:0]            paddr_o,
  output logic [NUM_SLAVES-1:0]            psel_o,
  output logic                             penable_o,
  output logic                             pwrite_o,
  output logic [DATA_WIDTH-1:0]            pwdata_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]            pready_i,
  input  logic [NUM_SLAVES-1:0]            pslverr_i
);
  localparam int IDX_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [IDX_W-1:0]        slot_q, slot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    accept, in_range, sel_ready, sel_err, tmo;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    unused_htrans;

  assign unused_htrans = htrans_i[0];
  assign accept    = hsel_i & hready_i & htrans_i[1] & (state_q == IDLE | state_q == ERR2);
  // Whole upper address field decodes, so addresses beyond the last slot error out
  assign in_range  = (haddr_i >> SLOT_BITS) < ADDR_WIDTH'(NUM_SLAVES);
  assign sel_ready = pready_i[slot_q];
  assign sel_err   = pslverr_i[slot_q];
  assign sel_rdata = prdata_i[slot_q*DATA_WIDTH +: DATA_WIDTH];
  assign tmo       = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    slot_d   = slot_q;
    cnt_d    = '0;
    if (accept) begin
      paddr_d  = haddr_i;
      pwrite_d = hwrite_i;
      slot_d   = haddr_i[SLOT_BITS +: IDX_W];
      state_d  = in_range ? LATCH : ERR1;
    end else begin
      case (state_q)
        LATCH: begin
          pwdata_d = pwrite_q ? hwdata_i : pwdata_q;
          state_d  = SETUP;
        end
        SETUP: state_d = ACCESS;
        ACCESS: begin
          cnt_d = cnt_q + 1'b1;
          if (sel_ready) begin
            state_d  = sel_err ? ERR1 : IDLE;
            hrdata_d = (!sel_err && !pwrite_q) ? sel_rdata : hrdata_q;
          end else if (tmo) begin
            state_d = ERR1;
          end
        end
        ERR1:    state_d = ERR2;
        ERR2:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
    end
  end

  assign psel_o      = (state_q == SETUP || state_q == ACCESS) ? NUM_SLAVES'(1) << slot_q : '0;
  assign penable_o   = state_q == ACCESS;
  assign hreadyout_o = state_q == IDLE || state_q == ERR2;
  assign hresp_o     = {1'b0, state_q == ERR1 || state_q == ERR2};
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign hrdata_o    = hrdata_q;
endmodule

// File: tb/tb_ahb_apb3_bridge_mc.sv
// tb_ahb_apb3_bridge_mc: directed AHB transfers into a queued scoreboard, with APB slave model and APB-side monitor.
module tb_ahb_apb3_bridge_mc;
  localparam int AW = 32, DW = 32, NS = 4, TO = 8;

  typedef struct {logic [DW-1:0] rdata; logic is_rd; logic err; int lat;} rsp_t;
  typedef struct {logic [NS-1:0] psel; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; int en;} apb_t;

  logic clk = 1'b0, rst = 1'b0;
  logic hsel = 1'b0, hwrite = 1'b0;
  logic [1:0] htrans = 2'b00;
  logic [AW-1:0] haddr = '0;
  logic [DW-1:0] hwdata = '0;
  logic [DW-1:0] hrdata_o, pwdata_o;
  logic hreadyout_o, penable_o, pwrite_o;
  logic [1:0] hresp_o;
  logic [AW-1:0] paddr_o;
  logic [NS-1:0] psel_o, pready_i, pslverr_i;
  logic [NS*DW-1:0] prdata_i;

  logic [DW-1:0] sd [NS];
  int wait_cfg [NS];
  logic err_cfg [NS];
  int acc_cnt = 0;

  rsp_t exp_q[$];
  apb_t apb_q[$];
  int checks = 0, errors = 0;
  logic [DW-1:0] exp_pwdata = '0;
  bit dp_start = 0, in_dp = 0, apb_act = 0;
  int lat = 0, en = 0, exp_en = 0;
  logic [1:0] prev_resp = 2'b00;

  always #5 clk = ~clk;

  ahb_apb3_bridge_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLOT_BITS(12), .TIMEOUT(TO)) dut (
    .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel), .hready_i(hreadyout_o), .hwrite_i(hwrite),
    .htrans_i(htrans), .haddr_i(haddr), .hwdata_i(hwdata), .hrdata_o(hrdata_o),
    .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i));

  for (genvar g = 0; g < NS; g++) begin : g_slv
    assign prdata_i[g*DW +: DW] = sd[g];
    assign pready_i[g]          = acc_cnt >= wait_cfg[g];
    assign pslverr_i[g]         = err_cfg[g];
  end

  always @(posedge clk) acc_cnt <= (|psel_o && penable_o) ? acc_cnt + 1 : 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk)
    if (!rst && hsel && htrans[1] && hreadyout_o) dp_start = 1;

  always @(negedge clk) begin
    rsp_t r;
    apb_t a;
    if (rst) begin
      in_dp = 0; dp_start = 0; apb_act = 0;
    end else begin
      if (dp_start) begin in_dp = 1; lat = 0; dp_start = 0; prev_resp = 2'b00; end
      if (in_dp) begin
        lat++;
        if (hreadyout_o) begin
          if (exp_q.size() == 0) chk("unexpected_completion", 1, 0);
          else begin
            r = exp_q.pop_front();
            chk("latency", lat, r.lat);
            chk("hresp", hresp_o, r.err ? 2'b01 : 2'b00);
            chk("hresp_prev", prev_resp, r.err ? 2'b01 : 2'b00);
            if (r.is_rd) chk("hrdata", hrdata_o, r.rdata);
          end
          in_dp = 0;
        end else prev_resp = hresp_o;
      end
      if (psel_o != 0 && !penable_o) begin
        if (apb_q.size() == 0) chk("unexpected_setup", psel_o, 0);
        else begin
          a = apb_q.pop_front();
          chk("psel", psel_o, a.psel);
          chk("paddr", paddr_o, a.addr);
          chk("pwrite", pwrite_o, a.wr);
          chk("pwdata", pwdata_o, a.wdata);
          exp_en = a.en; en = 0; apb_act = 1;
        end
      end else if (psel_o != 0) en++;
      else if (apb_act) begin
        chk("penable_cycles", en, exp_en);
        apb_act = 0;
      end
    end
  end

  task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd, input int slot,
                       input int wt, input logic er, input logic err, input int lt, input int ne);
    bit ok = 0;
    rsp_t r;
    apb_t a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hreadyout_o) begin ok = 1; break; end
    end
    if (!ok) chk("ready_wait_timeout", 0, 1);
    if (slot >= 0) begin
      wait_cfg[slot] = wt; err_cfg[slot] = er;
      if (wr) exp_pwdata = wd;
      a.psel = NS'(1) << slot; a.addr = addr; a.wr = wr; a.wdata = exp_pwdata; a.en = ne;
      apb_q.push_back(a);
    end
    r.rdata = slot >= 0 ? sd[slot] : '0; r.is_rd = !wr && !err; r.err = err; r.lat = lt;
    exp_q.push_back(r);
    hsel = 1; htrans = 2'b10; haddr = addr; hwrite = wr;
    @(negedge clk);
    hsel = 0; htrans = 2'b00; hwdata = wd;
  endtask

  task automatic reset_checks(input string t);
    chk({t, "_hreadyout"}, hreadyout_o, 1);
    chk({t, "_hresp"}, hresp_o, 0);
    chk({t, "_hrdata"}, hrdata_o, 0);
    chk({t, "_psel"}, psel_o, 0);
    chk({t, "_penable"}, penable_o, 0);
    chk({t, "_pwrite"}, pwrite_o, 0);
    chk({t, "_paddr"}, paddr_o, 0);
    chk({t, "_pwdata"}, pwdata_o, 0);
  endtask

  initial begin
    sd[0] = 32'hA5A50000; sd[1] = 32'h12345678; sd[2] = 32'h0BADF00D; sd[3] = 32'hCAFE0003;
    for (int k = 0; k < NS; k++) begin wait_cfg[k] = 0; err_cfg[k] = 0; end
    #1 rst = 1;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    #2 rst = 0;
    // BUSY with HSEL, then NONSEQ without HSEL: neither is accepted
    @(negedge clk); hsel = 1; htrans = 2'b01; haddr = 32'h2000;
    repeat (2) @(negedge clk);
    chk("busy_hreadyout", hreadyout_o, 1);
    chk("busy_psel", psel_o, 0);
    hsel = 0; htrans = 2'b10;
    repeat (2) @(negedge clk);
    chk("nosel_hreadyout", hreadyout_o, 1);
    chk("nosel_hresp", hresp_o, 0);
    htrans = 2'b00;
    issue(32'h2010, 1, 32'hDEADBEEF, 2, 0, 0, 0, 4, 1);
    issue(32'h1004, 0, 32'hBAD0BAD0, 1, 3, 0, 0, 7, 4);
    issue(32'h5000, 0, 32'hBAD0BAD0, -1, 0, 0, 1, 2, 0);
    issue(32'h0008, 0, 32'hBAD0BAD0, 0, 0, 1, 1, 5, 1);
    issue(32'h3000, 1, 32'h0000FEED, 3, 255, 0, 1, 12, 8);
    issue(32'h3004, 0, 32'hBAD0BAD0, 3, 0, 0, 0, 4, 1);
    issue(32'h2ffc, 0, 32'hBAD0BAD0, 2, 0, 0, 0, 4, 1);
    issue(32'h0100, 0, 32'hBAD0BAD0, 0, 7, 0, 0, 11, 8);
    // Abort a stalled read with reset during ACCESS
    issue(32'h3100, 0, 32'hBAD0BAD0, 3, 255, 0, 1, 12, 8);
    repeat (2) @(negedge clk);
    chk("pre_reset_penable", penable_o, 1);
    #2 rst = 1;
    #1 reset_checks("midreset");
    exp_q.delete();
    exp_pwdata = '0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    issue(32'h0040, 1, 32'h55AA55AA, 0, 0, 0, 0, 4, 1);
    issue(32'h1040, 0, 32'hBAD0BAD0, 1, 0, 0, 0, 4, 1);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || in_dp || apb_act); i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("apb_queue_drained", apb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
